sub_pipe: RTL



---
 rtl/arith_pkg.sv | 16 +
 rtl/sub_chunk.sv | 19 +
 rtl/sub_pipe.sv | 105 ++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-pipeline constants and helpers for the adder/subtractor cells.
package arith_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_STAGES = 4;

   function automatic int chunk_of(input int width, input int stages);
      return width / stages;
   endfunction

   // A legal split resolves an equal, non-empty slice of bits in every stage.
   function automatic bit chunk_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK-bit subtract slice: d = a - b - bin, bout set on underflow.
module sub_chunk #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic [W-1:0] d,
   output logic         bout
);

   logic [W:0] full;

   // One extra bit captures the borrow as the sign of the widened difference.
   assign full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
   assign d    = full[W-1:0];
   assign bout = full[W];

endmodule

// File: rtl/sub_pipe.sv
// Pipelined a - b with the borrow rippling one chunk per register stage; the
// whole pipe advances together whenever the output slot is free or being drained.
module sub_pipe
   import arith_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int CHUNK = chunk_of(WIDTH, STAGES);
   localparam int LAST  = STAGES - 1;

   if (!chunk_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("sub_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
   end

   logic                          adv;
   logic [STAGES-1:0]             v_q;
   logic [STAGES-1:0]             bo_q;
   logic [STAGES-1:0][WIDTH-1:0]  a_q;
   logic [STAGES-1:0][WIDTH-1:0]  b_q;
   logic [STAGES-1:0][WIDTH-1:0]  d_q;
   logic                          ovf_q;

   logic [STAGES-1:0]             v_src;
   logic [STAGES-1:0]             bin;
   logic [STAGES-1:0][WIDTH-1:0]  a_src;
   logic [STAGES-1:0][WIDTH-1:0]  b_src;
   logic [STAGES-1:0][WIDTH-1:0]  d_src;
   logic [STAGES-1:0][WIDTH-1:0]  d_nxt;
   logic [STAGES-1:0][CHUNK-1:0]  cd;
   logic [STAGES-1:0]             cbo;
   logic                          ovf_nxt;

   // Handshake: a transfer happens on a side when its valid and ready are both
   // high at a rising edge; ready never depends on the same side's valid.
   assign adv      = !v_q[LAST] || out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign v_src[k] = in_valid && in_ready;
         assign a_src[k] = a;
         assign b_src[k] = b;
         assign d_src[k] = '0;
         assign bin[k]   = 1'b0;
      end else begin : g_rest
         assign v_src[k] = v_q[k-1];
         assign a_src[k] = a_q[k-1];
         assign b_src[k] = b_q[k-1];
         assign d_src[k] = d_q[k-1];
         assign bin[k]   = bo_q[k-1];
      end

      sub_chunk #(.W(CHUNK)) u_chunk (
         .a    (a_src[k][k*CHUNK +: CHUNK]),
         .b    (b_src[k][k*CHUNK +: CHUNK]),
         .bin  (bin[k]),
         .d    (cd[k]),
         .bout (cbo[k])
      );

      // Bits above the chunks resolved so far are always zero, so OR-ing in place is exact.
      assign d_nxt[k] = d_src[k] | (WIDTH'(cd[k]) << (k * CHUNK));
   end

   assign ovf_nxt = (a_src[LAST][WIDTH-1] != b_src[LAST][WIDTH-1]) &&
                    (d_nxt[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q   <= '0;
         bo_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         d_q   <= '0;
         ovf_q <= 1'b0;
      end else if (adv) begin
         v_q   <= v_src;
         bo_q  <= cbo;
         a_q   <= a_src;
         b_q   <= b_src;
         d_q   <= d_nxt;
         ovf_q <= ovf_nxt;
      end
   end

   assign out_valid = v_q[LAST];
   assign diff      = d_q[LAST];
   assign borrow    = bo_q[LAST];
   assign ovf       = ovf_q;

endmodule
